// File: rtl/pwm_fade_pkg.sv
// Shared types and arithmetic helpers for the PWM fade controller.
// The breathe (triangle) feature is built only when PWM_FADE_BREATHE_EN is defined.
package pwm_fade_pkg;

    localparam int PWM_R = 10;

    typedef enum logic [0:0] {
        IDLE = 1'b0,
        RAMP = 1'b1
    } fade_state_e;

    function automatic logic [31:0] clamp_target(input logic [31:0] tgt, input logic [31:0] max_val);
        logic [31:0] res;
        if (tgt > max_val) begin
            res = max_val;
        end else begin
            res = tgt;
        end
        return res;
    endfunction

    // One step of cur toward tgt by stp, saturating at tgt; the 33-bit sum cannot wrap.
    function automatic logic [31:0] fade_step(input logic [31:0] cur, input logic [31:0] tgt,
                                              input logic [31:0] stp);
        logic [32:0] sum;
        logic [31:0] gap;
        logic [31:0] res;
        sum = {1'b0, cur} + {1'b0, stp};
        gap = 32'd0;
        if (cur < tgt) begin
            if (sum >= {1'b0, tgt}) begin
                res = tgt;
            end else begin
                res = sum[31:0];
            end
        end else if (cur > tgt) begin
            gap = cur - tgt;
            if (stp >= gap) begin
                res = tgt;
            end else begin
                res = cur - stp;
            end
        end else begin
            res = cur;
        end
        return res;
    endfunction

endpackage

// File: rtl/pwm_fade_timer.sv
// Step-interval counter: counts 0..interval while enabled and ticks on the wrap.
module pwm_fade_timer (
    input  logic        clk,
    input  logic        reset_n,
    input  logic        clr,
    input  logic        en,
    input  logic [31:0] interval,
    output logic        tick
);

    logic [31:0] cnt_q;
    logic [31:0] cnt_d;

    assign tick = en && (cnt_q == interval);

    // Next count: cleared outside a ramp, wraps to zero on the tick.
    always_comb begin
        cnt_d = cnt_q;
        if (clr) begin
            cnt_d = 32'd0;
        end else if (en) begin
            if (cnt_q == interval) begin
                cnt_d = 32'd0;
            end else begin
                cnt_d = cnt_q + 32'd1;
            end
        end else begin
            cnt_d = 32'd0;
        end
    end

    // Counter register.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            cnt_q <= 32'd0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

endmodule

// File: rtl/pwm_fade_ctrl.sv
// Duty-cycle ramp controller feeding the PWM core's duty input.
// Define PWM_FADE_BREATHE_EN to build the continuous triangle (breathe) mode.
module pwm_fade_ctrl
    import pwm_fade_pkg::*;
#(
    parameter int R = PWM_R
) (
    input  logic          clk,
    input  logic          reset_n,
    input  logic          start,
    input  logic          abort,
    input  logic [R:0]    target,
    input  logic [R:0]    step,
    input  logic [31:0]   interval,
    input  logic          breathe,
    output logic [R:0]    duty,
    output logic          busy,
    output logic          done
);

    localparam int          DW         = R + 1;
    localparam int          PADW       = 31 - R;
    localparam logic [31:0] FULL_SCALE = 32'd1 << R;

    fade_state_e state_q, state_d;
    logic [R:0]  duty_q, duty_d;
    logic [R:0]  tgt_q, tgt_d;
    logic [R:0]  step_q, step_d;
    logic [31:0] intv_q, intv_d;
    logic        busy_q, busy_d;
    logic        done_q, done_d;

    logic        tick_s;
    logic        tmr_clr_s;
    logic        tmr_en_s;
    logic        breathe_s;
    logic [R:0]  tgt_in_s;
    logic [R:0]  step_in_s;
    logic [R:0]  eff_tgt_s;
    logic [R:0]  next_duty_s;

`ifdef PWM_FADE_BREATHE_EN
    logic        brth_q, brth_d;
    logic        dir_q, dir_d;

    assign breathe_s = breathe;
    // In breathe mode the falling half of the triangle heads for zero.
    assign eff_tgt_s = (brth_q && !dir_q) ? {DW{1'b0}} : tgt_q;
`else
    logic        unused_breathe_s;

    assign unused_breathe_s = breathe;
    assign breathe_s        = 1'b0;
    assign eff_tgt_s        = tgt_q;
`endif

    assign tgt_in_s    = DW'(clamp_target({{PADW{1'b0}}, target}, FULL_SCALE));
    assign step_in_s   = (step == {DW{1'b0}}) ? {{R{1'b0}}, 1'b1} : step;
    assign next_duty_s = DW'(fade_step({{PADW{1'b0}}, duty_q}, {{PADW{1'b0}}, eff_tgt_s},
                                       {{PADW{1'b0}}, step_q}));

    assign tmr_en_s  = (state_q == RAMP);
    assign tmr_clr_s = abort || start || (state_q != RAMP);

    pwm_fade_timer u_timer (
        .clk      (clk),
        .reset_n  (reset_n),
        .clr      (tmr_clr_s),
        .en       (tmr_en_s),
        .interval (intv_q),
        .tick     (tick_s)
    );

    // FSM and datapath next-state: abort beats start, start beats a pending step.
    always_comb begin
        state_d = state_q;
        duty_d  = duty_q;
        tgt_d   = tgt_q;
        step_d  = step_q;
        intv_d  = intv_q;
        busy_d  = busy_q;
        done_d  = 1'b0;
`ifdef PWM_FADE_BREATHE_EN
        brth_d  = brth_q;
        dir_d   = dir_q;
`endif
        if (abort) begin
            state_d = IDLE;
            busy_d  = 1'b0;
        end else if (start) begin
            tgt_d  = tgt_in_s;
            step_d = step_in_s;
            intv_d = interval;
`ifdef PWM_FADE_BREATHE_EN
            brth_d = breathe;
            dir_d  = (duty_q != tgt_in_s);
`endif
            if ((duty_q == tgt_in_s) && !breathe_s) begin
                state_d = IDLE;
                busy_d  = 1'b0;
                done_d  = 1'b1;
            end else begin
                state_d = RAMP;
                busy_d  = 1'b1;
                done_d  = (duty_q == tgt_in_s);
            end
        end else begin
            case (state_q)
                IDLE: begin
                    state_d = IDLE;
                end
                RAMP: begin
                    if (tick_s) begin
                        duty_d = next_duty_s;
                        if (next_duty_s == eff_tgt_s) begin
                            done_d = 1'b1;
`ifdef PWM_FADE_BREATHE_EN
                            if (brth_q) begin
                                dir_d = !dir_q;
                            end else begin
                                state_d = IDLE;
                                busy_d  = 1'b0;
                            end
`else
                            state_d = IDLE;
                            busy_d  = 1'b0;
`endif
                        end else begin
                            done_d = 1'b0;
                        end
                    end else begin
                        duty_d = duty_q;
                    end
                end
                default: begin
                    state_d = IDLE;
                    busy_d  = 1'b0;
                end
            endcase
        end
    end

    // State, configuration and registered outputs.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q <= IDLE;
            duty_q  <= {DW{1'b0}};
            tgt_q   <= {DW{1'b0}};
            step_q  <= {{R{1'b0}}, 1'b1};
            intv_q  <= 32'd0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
`ifdef PWM_FADE_BREATHE_EN
            brth_q  <= 1'b0;
            dir_q   <= 1'b0;
`endif
        end else begin
            state_q <= state_d;
            duty_q  <= duty_d;
            tgt_q   <= tgt_d;
            step_q  <= step_d;
            intv_q  <= intv_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
`ifdef PWM_FADE_BREATHE_EN
            brth_q  <= brth_d;
            dir_q   <= dir_d;
`endif
        end
    end

    assign duty = duty_q;
    assign busy = busy_q;
    assign done = done_q;

endmodule

// File: tb/tb_pwm_fade_ctrl.sv
// Table-driven bench for pwm_fade_ctrl (R=10) with hand-written multi-cycle sequences.
module tb_pwm_fade_ctrl;

    logic        clk;
    logic        reset_n;
    logic        start;
    logic        abort;
    logic [10:0] target;
    logic [10:0] step;
    logic [31:0] interval;
    logic        breathe;
    logic [10:0] duty;
    logic        busy;
    logic        done;

    int checks;
    int failures;

    typedef struct {
        logic        start;
        logic        abort;
        logic [10:0] target;
        logic [10:0] step;
        logic [31:0] interval;
        logic        breathe;
        logic [10:0] e_duty;
        logic        e_busy;
        logic        e_done;
    } vec_t;

    vec_t vecs[$];

    pwm_fade_ctrl #(.R(10)) dut (
        .clk      (clk),
        .reset_n  (reset_n),
        .start    (start),
        .abort    (abort),
        .target   (target),
        .step     (step),
        .interval (interval),
        .breathe  (breathe),
        .duty     (duty),
        .busy     (busy),
        .done     (done)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0d expected=%0d", name, act, exp);
        end
    endtask

    function automatic void add(input logic s, input logic a, input logic [10:0] t,
                                input logic [10:0] st, input logic [31:0] iv, input logic br,
                                input logic [10:0] ed, input logic eb, input logic edn);
        vec_t v;
        v.start = s;   v.abort = a;     v.target = t;  v.step = st;
        v.interval = iv; v.breathe = br; v.e_duty = ed; v.e_busy = eb; v.e_done = edn;
        vecs.push_back(v);
    endfunction

    // A cycle with no command; the config inputs carry junk that must be ignored.
    function automatic void idle(input logic [10:0] ed, input logic eb, input logic edn);
        add(1'b0, 1'b0, 11'd7, 11'd3, 32'd9, 1'b0, ed, eb, edn);
    endfunction

    task automatic cycle_cmd(input logic s, input logic a, input logic [10:0] t,
                             input logic [10:0] st, input logic [31:0] iv, input logic br);
        start = s; abort = a; target = t; step = st; interval = iv; breathe = br;
        @(posedge clk);
        #1;
        start = 1'b0;
        abort = 1'b0;
    endtask

    initial begin
        int   cyc;
        logic mono_ok;

        checks   = 0;
        failures = 0;
        reset_n  = 1'b0;
        start    = 1'b0;
        abort    = 1'b0;
        target   = 11'd0;
        step     = 11'd0;
        interval = 32'd0;
        breathe  = 1'b0;

        // Ramp 0 -> 100 by 10, one step every 5 clocks.
        add(1'b1, 1'b0, 11'd100, 11'd10, 32'd4, 1'b0, 11'd0, 1'b1, 1'b0);
        for (int k = 1; k <= 10; k++) begin
            for (int j = 0; j < 4; j++) idle(11'((k - 1) * 10), 1'b1, 1'b0);
            idle(11'(k * 10), 1'(k < 10), 1'(k == 10));
        end
        idle(11'd100, 1'b0, 1'b0);
        // Ramp down with a saturating last step.
        add(1'b1, 1'b0, 11'd35, 11'd30, 32'd0, 1'b0, 11'd100, 1'b1, 1'b0);
        idle(11'd70, 1'b1, 1'b0);
        idle(11'd40, 1'b1, 1'b0);
        idle(11'd35, 1'b0, 1'b1);
        idle(11'd35, 1'b0, 1'b0);
        // Start with duty already at target.
        add(1'b1, 1'b0, 11'd35, 11'd9, 32'd3, 1'b0, 11'd35, 1'b0, 1'b1);
        idle(11'd35, 1'b0, 1'b0);
        // Abort at 50.
        add(1'b1, 1'b0, 11'd80, 11'd5, 32'd0, 1'b0, 11'd35, 1'b1, 1'b0);
        idle(11'd40, 1'b1, 1'b0);
        idle(11'd45, 1'b1, 1'b0);
        idle(11'd50, 1'b1, 1'b0);
        add(1'b0, 1'b1, 11'd7, 11'd3, 32'd9, 1'b0, 11'd50, 1'b0, 1'b0);
        idle(11'd50, 1'b0, 1'b0);
        // Start and abort together: abort wins.
        add(1'b1, 1'b1, 11'd0, 11'd1, 32'd0, 1'b0, 11'd50, 1'b0, 1'b0);
        idle(11'd50, 1'b0, 1'b0);
        // interval=1 with changing inputs after start.
        add(1'b1, 1'b0, 11'd60, 11'd10, 32'd1, 1'b0, 11'd50, 1'b1, 1'b0);
        idle(11'd50, 1'b1, 1'b0);
        idle(11'd60, 1'b0, 1'b1);
        idle(11'd60, 1'b0, 1'b0);
        // Restart during a ramp, just before a step is due.
        add(1'b1, 1'b0, 11'd100, 11'd10, 32'd2, 1'b0, 11'd60, 1'b1, 1'b0);
        idle(11'd60, 1'b1, 1'b0);
        idle(11'd60, 1'b1, 1'b0);
        add(1'b1, 1'b0, 11'd0, 11'd25, 32'd0, 1'b0, 11'd60, 1'b1, 1'b0);
        idle(11'd35, 1'b1, 1'b0);
        idle(11'd10, 1'b1, 1'b0);
        idle(11'd0, 1'b0, 1'b1);
        idle(11'd0, 1'b0, 1'b0);
        // Breathe request.
        add(1'b1, 1'b0, 11'd40, 11'd20, 32'd0, 1'b1, 11'd0, 1'b1, 1'b0);
`ifdef PWM_FADE_BREATHE_EN
        idle(11'd20, 1'b1, 1'b0);
        idle(11'd40, 1'b1, 1'b1);
        idle(11'd20, 1'b1, 1'b0);
        idle(11'd0, 1'b1, 1'b1);
        idle(11'd20, 1'b1, 1'b0);
        idle(11'd40, 1'b1, 1'b1);
        add(1'b0, 1'b1, 11'd7, 11'd3, 32'd9, 1'b0, 11'd40, 1'b0, 1'b0);
        idle(11'd40, 1'b0, 1'b0);
`else
        idle(11'd20, 1'b1, 1'b0);
        idle(11'd40, 1'b0, 1'b1);
        idle(11'd40, 1'b0, 1'b0);
`endif

        repeat (2) @(posedge clk);
        #1;
        chk("in_reset duty", 32'(duty), 32'd0);
        reset_n = 1'b1;
        @(posedge clk);
        #1;
        chk("reset duty", 32'(duty), 32'd0);
        chk("reset busy", 32'(busy), 32'd0);
        chk("reset done", 32'(done), 32'd0);

        for (int i = 0; i < vecs.size(); i++) begin
            cycle_cmd(vecs[i].start, vecs[i].abort, vecs[i].target, vecs[i].step,
                      vecs[i].interval, vecs[i].breathe);
            chk($sformatf("v%0d duty", i), 32'(duty), 32'(vecs[i].e_duty));
            chk($sformatf("v%0d busy", i), 32'(busy), 32'(vecs[i].e_busy));
            chk($sformatf("v%0d done", i), 32'(done), 32'(vecs[i].e_done));
        end

        // Asynchronous reset in the middle of a ramp from 40.
        cycle_cmd(1'b1, 1'b0, 11'd500, 11'd7, 32'd0, 1'b0);
        repeat (3) @(posedge clk);
        #1;
        chk("pre_reset duty", 32'(duty), 32'd61);
        #2;
        reset_n = 1'b0;
        #1;
        chk("async_reset duty", 32'(duty), 32'd0);
        chk("async_reset busy", 32'(busy), 32'd0);
        @(posedge clk);
        #1;
        reset_n = 1'b1;
        @(posedge clk);
        #1;
        chk("post_reset duty", 32'(duty), 32'd0);
        chk("post_reset busy", 32'(busy), 32'd0);

        // Target 2000 clamps to 1024 and step 0 acts as 1: 1024 single steps.
        cycle_cmd(1'b1, 1'b0, 11'd2000, 11'd0, 32'd0, 1'b0);
        chk("clamp start busy", 32'(busy), 32'd1);
        cyc     = 0;
        mono_ok = 1'b1;
        while (cyc < 1100) begin
            @(posedge clk);
            #1;
            cyc++;
            if (duty !== 11'(cyc)) mono_ok = 1'b0;
            if (done === 1'b1) break;
        end
        chk("clamp steps", 32'(cyc), 32'd1024);
        chk("clamp duty", 32'(duty), 32'd1024);
        chk("clamp monotonic", 32'(mono_ok), 32'd1);
        chk("clamp end busy", 32'(busy), 32'd0);
        @(posedge clk);
        #1;
        chk("clamp after done", 32'(done), 32'd0);
        chk("clamp hold duty", 32'(duty), 32'd1024);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
